// File: rtl/light_pkg.sv
// Shared types and constants for the round-robin LED chaser scheduler.
package light_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [7:0] LUMP_START       = 8'h80;
  localparam int         N_STEPS          = 8;
  localparam int         TICK_DIV_DEFAULT = 50_000_000;

endpackage

// File: rtl/tick_gen.sv
// Free-running step divider: one-cycle tick every TICK_DIV clocks, restartable via clr.
module tick_gen
  import light_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/light_sched.sv
// Round-robin scheduler that lends one shared 8-LED chaser to N_REQ players,
// one full sweep per grant, with a one-tick blank gap between sweeps.
module light_sched
  import light_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT,
  parameter int N_REQ    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             abort,
  output logic [7:0]       lump,
  output logic             busy,
  output logic [1:0]       owner,
  output logic [N_REQ-1:0] grant,
  output logic             done,
  output logic [N_REQ-1:0] pending
);

  state_t           state, state_nxt;
  logic [7:0]       lump_nxt;
  logic [1:0]       owner_nxt;
  logic [1:0]       last_owner, last_owner_nxt;
  logic [N_REQ-1:0] grant_nxt;
  logic             done_nxt;
  logic [N_REQ-1:0] pending_nxt;
  logic [N_REQ-1:0] clr_mask;
  logic [2:0]       step, step_nxt;
  logic             clr_own;
  logic             tick_clr;
  logic             tick;
  logic             found;
  logic [1:0]       winner;
  logic [1:0]       cand;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .clr   (tick_clr),
    .tick  (tick)
  );

  assign busy = (state != IDLE);

  // Round-robin search starts just after the previous owner and wraps.
  always_comb begin
    found  = 1'b0;
    winner = last_owner;
    cand   = last_owner;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = 2'((int'(last_owner) + i) % N_REQ);
      if (!found && pending[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    lump_nxt       = lump;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    grant_nxt      = '0;
    done_nxt       = 1'b0;
    step_nxt       = step;
    clr_own        = 1'b0;
    tick_clr       = 1'b0;

    case (state)
      IDLE: begin
        if (found) begin
          grant_nxt[winner] = 1'b1;
          owner_nxt         = winner;
          last_owner_nxt    = winner;
          lump_nxt          = LUMP_START;
          step_nxt          = 3'd0;
          tick_clr          = 1'b1;
          state_nxt         = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          lump_nxt  = 8'h00;
          clr_own   = 1'b1;
          state_nxt = IDLE;
        end else if (tick) begin
          if (step == 3'(N_STEPS - 1)) begin
            lump_nxt  = 8'h00;
            done_nxt  = 1'b1;
            clr_own   = 1'b1;
            state_nxt = GAP;
          end else begin
            lump_nxt = lump >> 1;
            step_nxt = step + 3'd1;
          end
        end
      end
      GAP: begin
        if (abort) begin
          lump_nxt  = 8'h00;
          clr_own   = 1'b1;
          state_nxt = IDLE;
        end else if (tick) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        lump_nxt  = 8'h00;
        state_nxt = IDLE;
      end
    endcase

    // New requests are OR-ed in after the clear so a same-cycle set wins.
    clr_mask = '0;
    if (clr_own) begin
      clr_mask[owner] = 1'b1;
    end
    pending_nxt = (pending & ~clr_mask) | req;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      lump       <= 8'h00;
      owner      <= 2'd0;
      last_owner <= 2'(N_REQ - 1);
      grant      <= '0;
      done       <= 1'b0;
      pending    <= '0;
      step       <= 3'd0;
    end else begin
      state      <= state_nxt;
      lump       <= lump_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
      grant      <= grant_nxt;
      done       <= done_nxt;
      pending    <= pending_nxt;
      step       <= step_nxt;
    end
  end

endmodule

// File: doc/light_sched.md
LIGHT_SCHED -- requirements
Module: light_sched

Interface
REQ-001 Parameter TICK_DIV, default 50_000_000, clock cycles per chase step.
REQ-002 Parameter N_REQ, default 4, number of requesters; fixed at 4 in this revision.
REQ-003 clk  in  1  single clock; all logic on posedge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 req  in  N_REQ  level start requests, one bit per player.
REQ-006 abort  in  1  cancels the current sweep.
REQ-007 lump  out  8  shared LED chaser pattern.
REQ-008 busy  out  1  high while the state is RUN or GAP.
REQ-009 owner  out  2  index of the requester that owns the chaser; holds its last value when idle.
REQ-010 grant  out  N_REQ  one-hot, one-cycle pulse when a sweep starts.
REQ-011 done  out  1  one-cycle pulse when a sweep completes normally.
REQ-012 pending  out  N_REQ  latched outstanding requests.

Function
REQ-013 The block SHALL have states IDLE, RUN and GAP.
REQ-014 Each cycle, pending SHALL be OR-ed with req, so a 1-cycle req pulse is never lost.
REQ-015 When a pending bit set and a pending bit clear hit the same cycle, the set SHALL win.
REQ-016 In IDLE with pending!=0, the block SHALL choose the first set bit after last_owner, wrapping modulo N_REQ; last_owner resets to N_REQ-1, so index 0 has first priority.
REQ-017 The grant edge SHALL do all of the following:
- grant=onehot(winner) for 1 cycle
- owner=winner, last_owner=winner
- lump=8'h80, step=0, busy=1
- tick counter cleared
- next state RUN
REQ-018 Latency: req sampled at edge k gives pending visible after edge k; the grant outputs SHALL appear after edge k+1.
REQ-019 In RUN, on each tick with step<7, lump SHALL shift right by one and step SHALL increment (8'h80, 8'h40 … 8'h01).
REQ-020 In RUN, on the tick with step==7, the block SHALL:
- set lump=8'h00
- pulse done
- clear pending[owner]
- go to GAP
REQ-021 GAP SHALL last exactly one tick, then return to IDLE; lump stays 8'h00 and busy stays 1.
REQ-022 A full sweep SHALL take 8*TICK_DIV cycles from grant to done, plus TICK_DIV cycles of GAP.
REQ-023 abort in RUN or GAP SHALL set lump=8'h00, clear pending[owner] and go to IDLE next cycle, with no done pulse.
REQ-024 abort in IDLE SHALL have no effect.
REQ-025 req bits asserted during RUN or GAP SHALL only latch into pending; they SHALL never pre-empt the current sweep.
REQ-026 An owner holding req high continuously SHALL re-arm its pending bit, but round-robin SHALL serve all other pending requesters first.
REQ-027 tick SHALL pulse for 1 cycle when the counter equals TICK_DIV-1; the counter then wraps to 0.

Reset
REQ-028 While reset==0 at a clock edge, the block SHALL set:
- state=IDLE
- lump=8'h00, busy=0, owner=0
- grant=0, done=0, pending=0
- step=0, tick counter=0
- last_owner=N_REQ-1
REQ-029 Reset asserted mid-sweep SHALL abandon the sweep with no done pulse, and all pending requests SHALL be discarded.
REQ-030 req SHALL be ignored in any cycle where reset==0.

Structure
REQ-031 Package light_pkg SHALL hold the state enum, LUMP_START=8'h80, N_STEPS=8 and the default TICK_DIV.
REQ-032 Sub-module tick_gen SHALL hold the tick counter, with ports clk, reset, clr and tick.
REQ-033 The state machine, round-robin pick and pending register SHALL live in light_sched.

Verification (TICK_DIV=4)
REQ-034 Release reset, pulse req=4'b0001 for 1 cycle -> grant=0001 two edges later, lump=80,40,…,01 every 4 cycles, then 00, done pulse 32 cycles after grant, busy low 4 cycles after done.
REQ-035 req=4'b1111 held for 1 cycle -> grants in order 0001, 0010, 0100, 1000, each after the previous GAP, and pending empties to 0000.
REQ-036 Owner 2 holds req[2] high while req[0] pulses -> next grant goes to 0, then back to 2.
REQ-037 abort at step 3 -> lump=00 next cycle, no done, pending[owner]=0, and the next pending requester is granted.
REQ-038 reset low at step 5 with pending=1010 -> all outputs return to reset values, pending=0000, and no grant after release.
REQ-039 req[1] pulses on the same cycle as done for owner 1 -> pending[1] remains 1 and owner 1 is granted again after GAP.
